// File: rtl/parity_frame_checker.sv
// Multi-channel serial parity frame checker: each channel receives WORD_BITS data
// bits LSB first plus one parity bit, and reports the word, a parity error and a
// saturating error count.
module parity_frame_checker #(
  parameter int WORD_BITS = 8,
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [CHANNELS-1:0]           x,
  input  logic [CHANNELS-1:0]           x_valid,
  input  logic                          odd,
  input  logic                          clear,
  output logic [CHANNELS-1:0]           z,
  output logic [CHANNELS-1:0]           done,
  output logic [CHANNELS-1:0]           err,
  output logic [CHANNELS*WORD_BITS-1:0] data,
  output logic [CHANNELS*CNT_W-1:0]     err_count,
  output logic [CHANNELS-1:0]           state_dbg
);

  localparam int BW = $clog2(WORD_BITS);
  localparam logic [0:0] ST_DATA = 1'b0;
  localparam logic [0:0] ST_PAR  = 1'b1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Strobe semantics: x[i] is consumed on every rising edge where x_valid[i]=1;
  // there is no back-pressure, so the checker accepts a bit on every cycle.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [0:0]           state;
    logic [BW-1:0]        bit_cnt;
    logic [WORD_BITS-1:0] shreg;
    logic                 z_r;
    logic                 done_r;
    logic                 err_r;
    logic [WORD_BITS-1:0] data_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 par_err;

    // Parity of the whole frame including the incoming bit, adjusted for mode.
    assign par_err = z_r ^ x[i] ^ odd;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state   <= ST_DATA;
        bit_cnt <= '0;
        shreg   <= '0;
        z_r     <= 1'b0;
        done_r  <= 1'b0;
        err_r   <= 1'b0;
        data_r  <= '0;
        cnt_r   <= '0;
      end else if (clear) begin
        state   <= ST_DATA;
        bit_cnt <= '0;
        shreg   <= '0;
        z_r     <= 1'b0;
        done_r  <= 1'b0;
        err_r   <= 1'b0;
        cnt_r   <= '0;
      end else begin
        done_r <= 1'b0;
        err_r  <= 1'b0;
        if (x_valid[i]) begin
          if (state == ST_DATA) begin
            shreg   <= {x[i], shreg[WORD_BITS-1:1]};
            z_r     <= z_r ^ x[i];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state <= ST_PAR;
          end else begin
            done_r  <= 1'b1;
            err_r   <= par_err;
            data_r  <= shreg;
            if (par_err && cnt_r != CNT_MAX) cnt_r <= cnt_r + 1'b1;
            z_r     <= 1'b0;
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end
      end
    end

    assign z[i]                             = z_r;
    assign done[i]                          = done_r;
    assign err[i]                           = err_r;
    assign data[i*WORD_BITS +: WORD_BITS]   = data_r;
    assign err_count[i*CNT_W +: CNT_W]      = cnt_r;
    assign state_dbg[i]                     = state;
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: a per-channel frame model pushes expected
// completions into queues that are popped whenever the DUT pulses done.
module tb_parity_frame_checker;
  localparam int WB = 8;
  localparam int CH = 4;
  localparam int CW = 4;
  localparam int EW = 1 + WB + CW;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [CH-1:0]    x, x_valid;
  logic             odd, clear;
  logic [CH-1:0]    z, done, err, state_dbg;
  logic [CH*WB-1:0] data;
  logic [CH*CW-1:0] err_count;

  parity_frame_checker #(.WORD_BITS(WB), .CHANNELS(CH), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .x(x), .x_valid(x_valid), .odd(odd),
    .clear(clear), .z(z), .done(done), .err(err), .data(data),
    .err_count(err_count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // frame model and scoreboard
  logic          m_z[CH];
  int            m_cnt[CH];
  logic [WB-1:0] m_word[CH];
  logic [WB-1:0] m_data[CH];
  logic [CW-1:0] m_err[CH];
  logic [CH-1:0] exp_done;
  logic [EW-1:0] exp_q[CH][$];
  logic          bitq[CH][$];
  int            mode[CH];

  task automatic check(input string tag, input int ch, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s ch%0d got=%0h exp=%0h", tag, ch, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_z[c] = 1'b0; m_cnt[c] = 0; m_word[c] = '0; m_data[c] = '0; m_err[c] = '0;
      exp_q[c].delete();
      bitq[c].delete();
    end
    exp_done = '0;
  endtask

  task automatic compare_outputs();
    logic [EW-1:0] ent;
    for (int c = 0; c < CH; c++) begin
      check("z", c, 32'(z[c]), 32'(m_z[c]));
      check("done", c, 32'(done[c]), 32'(exp_done[c]));
      if (done[c]) begin
        if (exp_q[c].size() == 0) begin
          check("spurious_done", c, 32'(1), 32'(0));
        end else begin
          ent = exp_q[c].pop_front();
          check("err", c, 32'(err[c]), 32'(ent[EW-1]));
          check("data", c, 32'(data[c*WB +: WB]), 32'(ent[CW +: WB]));
          check("err_count", c, 32'(err_count[c*CW +: CW]), 32'(ent[CW-1:0]));
        end
      end else begin
        check("err_idle", c, 32'(err[c]), 32'(0));
        check("data_hold", c, 32'(data[c*WB +: WB]), 32'(m_data[c]));
        check("err_count_hold", c, 32'(err_count[c*CW +: CW]), 32'(m_err[c]));
      end
    end
  endtask

  // driver: apply inputs, let one edge happen, update model, compare on negedge
  task automatic cycle(input logic [CH-1:0] v, input logic [CH-1:0] xb, input logic clr);
    logic e;
    x = xb; x_valid = v; clear = clr;
    @(posedge clock);
    cyc++;
    exp_done = '0;
    if (reset_n) begin
      for (int c = 0; c < CH; c++) begin
        if (clr) begin
          m_z[c] = 1'b0; m_cnt[c] = 0; m_err[c] = '0;
        end else if (v[c]) begin
          if (m_cnt[c] < WB) begin
            m_word[c][m_cnt[c]] = xb[c];
            m_z[c] = m_z[c] ^ xb[c];
            m_cnt[c]++;
          end else begin
            e = m_z[c] ^ xb[c] ^ odd;
            if (e && m_err[c] != 4'hF) m_err[c] = m_err[c] + 1'b1;
            m_data[c] = m_word[c];
            exp_q[c].push_back({e, m_word[c], m_err[c]});
            exp_done[c] = 1'b1;
            m_z[c] = 1'b0;
            m_cnt[c] = 0;
          end
        end
      end
    end
    @(negedge clock);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, CH'($urandom_range(0, 15)), 1'b0);
  endtask

  task automatic queue_frame(input int ch, input logic [WB-1:0] w, input logic p);
    for (int b = 0; b < WB; b++) bitq[ch].push_back(w[b]);
    bitq[ch].push_back(p);
  endtask

  task automatic run_frames(input int budget);
    logic [CH-1:0] v, xb;
    logic busy;
    for (int n = 0; n < budget; n++) begin
      busy = 1'b0;
      for (int c = 0; c < CH; c++) if (bitq[c].size() > 0) busy = 1'b1;
      if (!busy) break;
      for (int c = 0; c < CH; c++) begin
        xb[c] = 1'($urandom_range(0, 1));
        v[c] = 1'b0;
        if (bitq[c].size() > 0) begin
          case (mode[c])
            0:       v[c] = 1'b1;
            1:       v[c] = 1'(cyc % 2);
            default: v[c] = 1'($urandom_range(0, 1));
          endcase
          if (v[c]) xb[c] = bitq[c].pop_front();
        end
      end
      cycle(v, xb, 1'b0);
    end
    busy = 1'b0;
    for (int c = 0; c < CH; c++) if (bitq[c].size() > 0) busy = 1'b1;
    if (busy) check("timeout", 0, 32'(1), 32'(0));
    idle(2);
  endtask

  task automatic feed_ch0(input int n);
    logic [CH-1:0] xb;
    for (int i = 0; i < n; i++) begin
      xb = CH'($urandom_range(0, 15));
      xb[0] = bitq[0].pop_front();
      cycle(CH'(1), xb, 1'b0);
    end
  endtask

  initial begin
    logic [WB-1:0] w, last3;
    logic [7:0] zs;
    logic [CH-1:0] xb;
    reset_n = 1'b0; x = '0; x_valid = '0; odd = 1'b0; clear = 1'b0;
    for (int c = 0; c < CH; c++) mode[c] = 0;
    model_reset();

    // 1: reset held with random activity, then release
    for (int i = 0; i < 5; i++)
      cycle(CH'($urandom_range(0, 15)), CH'($urandom_range(0, 15)), 1'b0);
    reset_n = 1'b1;
    idle(2);

    // 2: even mode, good frame 0x5A, z sequence checked bit by bit
    zs = 8'b0011_0110;
    queue_frame(0, 8'h5A, 1'b0);
    for (int i = 0; i < WB + 1; i++) begin
      xb = CH'($urandom_range(0, 15));
      xb[0] = bitq[0].pop_front();
      cycle(CH'(1), xb, 1'b0);
      if (i < WB) check("z_seq", 0, 32'(z[0]), 32'(zs[i]));
    end
    idle(1);
    check("s2_data", 0, 32'(data[7:0]), 32'h5A);
    check("s2_cnt", 0, 32'(err_count[3:0]), 32'(0));

    // 3: even mode, bad parity
    queue_frame(0, 8'h5A, 1'b1);
    run_frames(50);
    check("s3_cnt", 0, 32'(err_count[3:0]), 32'(1));

    // 4: odd mode on ch1
    odd = 1'b1;
    queue_frame(1, 8'h01, 1'b0);
    queue_frame(1, 8'h01, 1'b1);
    run_frames(50);
    check("s4_cnt", 1, 32'(err_count[7:4]), 32'(1));
    odd = 1'b0;

    // 5: saturation on ch2, toggling strobe good frames on ch3, random traffic elsewhere
    mode[0] = 2; mode[1] = 2; mode[2] = 0; mode[3] = 1;
    last3 = '0;
    for (int f = 0; f < 17; f++) begin
      w = WB'($urandom_range(0, 255));
      queue_frame(2, w, ~^w);
    end
    for (int f = 0; f < 6; f++) begin
      w = WB'($urandom_range(0, 255));
      queue_frame(3, w, ^w);
      last3 = w;
    end
    for (int f = 0; f < 4; f++) begin
      w = WB'($urandom_range(0, 255));
      queue_frame(0, w, ^w);
      queue_frame(1, w, 1'($urandom_range(0, 1)));
    end
    run_frames(2000);
    check("s5_sat", 2, 32'(err_count[11:8]), 32'(15));
    check("s5_cnt3", 3, 32'(err_count[15:12]), 32'(0));
    check("s5_data3", 3, 32'(data[31:24]), 32'(last3));
    for (int c = 0; c < CH; c++) mode[c] = 0;

    // 6a: clear mid-frame, bit on the clear edge is discarded
    w = data[7:0];
    queue_frame(0, 8'hA5, 1'b0);
    feed_ch0(4);
    bitq[0].delete();
    cycle('1, CH'($urandom_range(0, 15)), 1'b1);
    check("clr_z", 0, 32'(z[0]), 32'(0));
    check("clr_cnt2", 2, 32'(err_count[11:8]), 32'(0));
    check("clr_data", 0, 32'(data[7:0]), 32'(w));
    queue_frame(0, 8'hC3, 1'b0);
    run_frames(50);
    check("clr_next", 0, 32'(data[7:0]), 32'hC3);

    // 6b: asynchronous reset between edges
    queue_frame(0, 8'h3C, 1'b1);
    feed_ch0(4);
    #2 reset_n = 1'b0;
    #1;
    check("arst_z", 0, 32'(z), 32'(0));
    check("arst_done", 0, 32'(done), 32'(0));
    check("arst_err", 0, 32'(err), 32'(0));
    check("arst_data", 0, data, 32'(0));
    check("arst_cnt", 0, 32'(err_count), 32'(0));
    model_reset();
    @(negedge clock);
    idle(2);
    reset_n = 1'b1;
    queue_frame(0, 8'h96, 1'b1);
    run_frames(50);
    check("arst_next_data", 0, 32'(data[7:0]), 32'h96);
    check("arst_next_cnt", 0, 32'(err_count[3:0]), 32'(1));

    idle(3);
    for (int c = 0; c < CH; c++) check("q_empty", c, 32'(exp_q[c].size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog ch0 got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Multi-channel, parametrised successor to the single-bit serial parity FSM.
- Each channel takes a serial bitstream in frames: WORD_BITS data bits (LSB first), then one parity bit.
- Per channel it tracks running parity, checks the parity bit in even or odd mode, captures the data word, flags errors and keeps a saturating error count.
- Sits between serial line receivers and the word-level consumer.

Parameters:
- WORD_BITS, 8, data bits per frame (>=2).
- CHANNELS, 4, number of independent serial channels.
- CNT_W, 4, width of the per-channel error counter.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- x  input  CHANNELS  serial data bit, one per channel.
- x_valid  input  CHANNELS  per-channel bit strobe; x[i] is sampled only when x_valid[i]=1.
- odd  input  1  parity mode shared by all channels: 0 = even, 1 = odd.
- clear  input  1  synchronous abort of all frames and clear of all counters.
- z  output  CHANNELS  registered running parity (XOR) of data bits received so far in the current frame.
- done  output  CHANNELS  one-cycle pulse when a frame's parity bit has been consumed.
- err  output  CHANNELS  parity error flag; meaningful only while done[i]=1, otherwise 0.
- data  output  CHANNELS*WORD_BITS  last completed word; channel i occupies bits [i*WORD_BITS +: WORD_BITS]; held until the next done.
- err_count  output  CHANNELS*CNT_W  per-channel saturating error count, packed the same way as data.

Behaviour:
- Reset (reset_n=0, asynchronous), per channel:
  - state=DATA, bit counter=0, shift register=0.
  - Outputs: z=0, done=0, err=0, data=0, err_count=0.
- Per-channel FSM with two states, DATA and PAR; channels never interact.
- DATA state, x_valid[i]=1:
  - Shift register takes x in from the MSB side, so the first bit received ends up at bit 0.
  - z[i] <= z[i]^x[i]; counter increments.
  - When the counter equals WORD_BITS-1 at this edge, go to PAR.
- PAR state, x_valid[i]=1 (parity bit):
  - done[i] <= 1.
  - err[i] <= z[i]^x[i]^odd. Even mode: error if the total count of ones (data + parity) is odd. Odd mode: error if it is even.
  - Data slice <= shift register contents.
  - If the error is set, err_count slice increments, saturating at 2^CNT_W-1 (no wrap).
  - z[i] <= 0, counter <= 0, return to DATA.
- Latency: done/err/data/err_count updates are visible in the cycle immediately after the edge that samples the parity bit.
- done and err are cleared on the next edge unless another parity bit is consumed on that edge. With x_valid held high, done can pulse at most once per WORD_BITS+1 cycles.
- x_valid[i]=0: channel i holds all state. The done/err pulse still ends after one cycle.
- odd is sampled only at the parity-bit edge; changing odd mid-frame has no other effect.
- clear=1, all channels:
  - state=DATA, counter=0, z=0, done=0, err=0, err_count=0.
  - data is retained.
  - clear has priority over x_valid on the same edge; the bit on that edge is discarded.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is lost and the next valid bit is data bit 0.

Test Plan:
1. Reset: hold reset_n=0 with random x/x_valid -> z=0, done=0, err=0, data=0, err_count=0 on all channels. Release reset -> no done pulses until 9 valid bits have been received on a channel.
2. Even, good frame: ch0, odd=0, x_valid=1 every cycle, bits 0,1,0,1,1,0,1,0 (0x5A), then parity 0.
   - z[0] sequence: 0,1,1,0,1,1,0,0.
   - done[0] pulses once; err[0]=0; data ch0=0x5A; err_count ch0=0.
3. Even, bad frame: repeat scenario 2 with parity bit 1 -> done[0] and err[0] both 1 for exactly one cycle; err_count ch0=1.
4. Odd mode, ch1, odd=1, data 0x01:
   - Parity 0 -> err=0.
   - Next frame with the same data and parity 1 -> err=1; err_count ch1=1.
5. Saturation and independence:
   - 17 bad frames on ch2 -> err_count ch2 stops at 15.
   - Concurrently ch3 carries good frames with x_valid toggling every other cycle -> err_count ch3=0 and data ch3 is correct.
6. Clear and mid-frame reset:
   - ch0 with 4 bits received, assert clear -> z[0]=0 and err_count=0, data unchanged. The next 9 valid bits form a complete frame.
   - Repeat with a reset_n pulse mid-frame between clock edges -> outputs go to 0 immediately, without waiting for a clock edge.
